segment_driver_n: RTL
=====================

Name: segment_driver_n

Overview:
Parametrised N-channel seven-segment animation driver, successor to the fixed 4-channel driver. A select bus routes debounced rising-edge events (next_segment_re, change_mode_re) to one channel. Each channel keeps its own segment position and display mode. The block drives a flat display bus; each channel's decimal point marks whether it is currently selected. It sits between the debounce/edge-detect stage and the board display pins.

Parameters:
CHANNELS, 4, number of display channels (1..16)
SEL_W, 2, width of sel; 2**SEL_W >= CHANNELS
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)
STEP_DIV, 12500000, clock cycles per auto-step (used only with SEG_AUTO_STEP_EN)
ACTIVE_LOW, 0, 1 = invert all 8 output bits per channel

Ports:
clk  in  1  system clock, all state on rising edge
async_reset  in  1  asynchronous, active-high reset
next_segment_re  in  1  single-cycle pulse: advance the selected channel
change_mode_re  in  1  single-cycle pulse: cycle the mode of the selected channel
sel  in  SEL_W  debounced channel select
display  out  8*CHANNELS  channel i occupies [8i+7:8i]; bit 7 = DP, bits 6..0 = segments a..g (bit k = segment k)

Behaviour:
- Reset is asynchronous, active-high, on clk domain. On reset every channel sets pos=0 and mode=SINGLE; blink counter=0 and phase=0 (segments shown); step counter=0.
- Reset output, ACTIVE_LOW=0: segment bits = 7'b0000001 for each channel. DP follows sel combinationally.
- Event routing: an event applies only to channel sel, in the cycle it is asserted. If sel >= CHANNELS, the event is dropped and no DP is lit.
- pos is 3 bits, range 0..6. next_segment_re sets pos to (pos==6) ? 0 : pos+1. Update is registered; the new pattern is visible the cycle after the pulse.
- change_mode_re moves to the next mode and forces pos=0.
  - Mode order without the optional feature: SINGLE -> FILL -> BLINK -> SINGLE.
- If next_segment_re and change_mode_re arrive in the same cycle, change_mode wins: mode advances, pos=0, and the next event is ignored.
- Segment patterns per mode:
  - SINGLE: only bit pos is set.
  - FILL: bits 0..pos are set (pos=6 gives 7'h7F).
  - BLINK: the SINGLE pattern when phase=0, all zeros when phase=1.
- Blink timer: a shared counter counts 0..BLINK_DIV-1. On wrap it toggles phase. It free-runs and is not affected by events.
- DP: display[8i+7] = (sel==i), combinational.
- ACTIVE_LOW=1: all 8 bits of every channel are inverted after the pattern is formed.
- Changing sel never alters any channel's state. Unselected channels keep animating (BLINK and AUTO continue).
- Segment outputs are decoded from registers only, so there are no combinational paths from the event inputs to display.

Optional Feature:
Macro SEG_AUTO_STEP_EN.
- Defined:
  - Adds mode AUTO; the mode order becomes SINGLE -> FILL -> BLINK -> AUTO -> SINGLE.
  - Adds a shared step counter 0..STEP_DIV-1. On each wrap, every channel in AUTO advances pos with the same wrap rule.
  - AUTO displays the SINGLE pattern.
  - A manual next_segment_re on an AUTO channel in the same cycle as a step tick advances pos once only.
- Undefined: no step counter and no AUTO encoding; the mode register is 2 bits with 3 legal values.

Decomposition:
- Package segment_pkg:
  - mode enum seg_mode_t (SINGLE, FILL, BLINK, AUTO);
  - constant SEG_COUNT=7;
  - pattern function seg_pattern(mode, pos, phase) returning 7 bits.
- Sub-module segment_channel holds one channel's pos/mode registers and its pattern decode. It takes next, change, blink_phase, and step_tick as inputs.
- The top level holds event demux, the shared counters, DP logic, polarity inversion, and a generate loop over CHANNELS.

Test Plan:
- Reset defaults (CHANNELS=4, sel=2): release reset -> every channel shows segments 7'h01; display = 32'h01_81_01_01.
- Position wrap: sel=1, 7 next pulses -> channel 1 steps 01,02,04,...,40,01; other channels stay at 01.
- FILL mode: sel=0, one change pulse then 3 next pulses -> channel 0 segments 7'h0F; a further 3 pulses -> 7'h7F; one more -> 7'h01.
- BLINK mode with BLINK_DIV=4: set channel 3 to BLINK -> segments toggle 01/00 every 4 cycles; this continues after sel moves to 0.
- Simultaneous events: pos=3 in SINGLE, next and change pulsed in the same cycle -> mode FILL, pos 0, segments 7'h01.
- ACTIVE_LOW=1, CHANNELS=3, SEL_W=2, sel=3 -> event pulses are ignored; every channel byte = 8'hFE.
- With SEG_AUTO_STEP_EN and STEP_DIV=5: put channel 2 in AUTO -> pos advances once every 5 cycles.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared types and pattern decode for the N-channel seven-segment animation driver.
// Build option SEG_AUTO_STEP_EN adds the AUTO mode.
package segment_pkg;

    localparam int SEG_COUNT = 7;
    localparam logic [SEG_COUNT-1:0] SEG_LSB = 7'd1;

`ifdef SEG_AUTO_STEP_EN
    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        FILL   = 2'd1,
        BLINK  = 2'd2,
        AUTO   = 2'd3
    } seg_mode_t;
`else
    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        FILL   = 2'd1,
        BLINK  = 2'd2
    } seg_mode_t;
`endif

    function automatic seg_mode_t seg_next_mode(seg_mode_t mode);
        seg_mode_t nxt;
        case (mode)
            SINGLE:  nxt = FILL;
            FILL:    nxt = BLINK;
`ifdef SEG_AUTO_STEP_EN
            BLINK:   nxt = AUTO;
            AUTO:    nxt = SINGLE;
`else
            BLINK:   nxt = SINGLE;
`endif
            default: nxt = SINGLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [SEG_COUNT-1:0] seg_pattern(seg_mode_t mode, logic [2:0] pos,
                                                        logic phase);
        logic [SEG_COUNT-1:0] single;
        logic [SEG_COUNT-1:0] pat;
        single = SEG_LSB << pos;
        case (mode)
            // Shifting the one-hot past bit 6 drops it, so pos=6 yields all ones.
            FILL:    pat = (single << 1) - SEG_LSB;
            BLINK:   pat = phase ? '0 : single;
            default: pat = single;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/segment_channel.sv
// One display channel: position and mode registers plus its segment pattern decode.
// With SEG_AUTO_STEP_EN, step_tick advances the position while in AUTO.
module segment_channel
    import segment_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 next,
    input  logic                 change,
    input  logic                 blink_phase,
    input  logic                 step_tick,
    output logic [SEG_COUNT-1:0] seg
);

    localparam logic [2:0] POS_LAST = 3'(SEG_COUNT - 1);

    logic [2:0] pos_q;
    logic [2:0] pos_d;
    seg_mode_t  mode_q;
    seg_mode_t  mode_d;
    logic       advance;

    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves a latch behind.
        pos_d   = pos_q;
        mode_d  = mode_q;
        advance = next;
`ifdef SEG_AUTO_STEP_EN
        // A manual pulse coinciding with a step tick still moves one position.
        if (mode_q == AUTO && step_tick) begin
            advance = 1'b1;
        end
`endif
        if (change) begin
            mode_d = seg_next_mode(mode_q);
            pos_d  = '0;
        end else if (advance) begin
            pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
        end
    end

`ifndef SEG_AUTO_STEP_EN
    logic unused_step_tick;
    assign unused_step_tick = step_tick;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses <= so every flop samples the values from before the edge.
        if (rst) begin
            pos_q  <= '0;
            mode_q <= SINGLE;
        end else begin
            pos_q  <= pos_d;
            mode_q <= mode_d;
        end
    end

    assign seg = seg_pattern(mode_q, pos_q, blink_phase);

endmodule

// File: rtl/segment_driver_n.sv
// N-channel seven-segment animation driver: event demux, shared blink/step timers, DP and polarity.
// Build option SEG_AUTO_STEP_EN enables the AUTO mode and its shared step counter.
module segment_driver_n
    import segment_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int SEL_W      = 2,
    parameter int BLINK_DIV  = 25000000,
    parameter int STEP_DIV   = 12500000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  next_segment_re,
    input  logic                  change_mode_re,
    input  logic [SEL_W-1:0]      sel,
    output logic [8*CHANNELS-1:0] display
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_d;
    logic               blink_phase_q;
    logic               blink_phase_d;
    logic               step_tick;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

`ifdef SEG_AUTO_STEP_EN
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [STEP_W-1:0] step_cnt_q;
    logic [STEP_W-1:0] step_cnt_d;

    always_comb begin
        step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_W'(1);
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_tick = (step_cnt_q == STEP_LAST);
`else
    logic unused_step_div;
    assign unused_step_div = (STEP_DIV > 0);
    assign step_tick       = 1'b0;
`endif

    // A select value with no matching channel lights no DP and drops its events.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                 hit;
        logic [SEG_COUNT-1:0] seg;
        logic [7:0]           pattern;

        assign hit = (sel == SEL_W'(i));

        segment_channel u_channel (
            .clk         (clk),
            .rst         (async_reset),
            .next        (next_segment_re & hit),
            .change      (change_mode_re & hit),
            .blink_phase (blink_phase_q),
            .step_tick   (step_tick),
            .seg         (seg)
        );

        assign pattern           = {hit, seg};
        assign display[8*i +: 8] = (ACTIVE_LOW != 0) ? ~pattern : pattern;
    end

endmodule
